// File: rtl/gfifo_mc_ififo_pkt_if.sv
// Handshake bundle for the multi-channel ingress packet FIFO.
// The slave side is the FIFO itself; the master side is the host/ingress
// driver together with the downstream consumer of the egress port.
interface gfifo_mc_ififo_pkt_if #(
    parameter int DW   = 256,
    parameter int NCH  = 4,
    parameter int LENW = 18
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    // ingress word stream
    logic            iValid;
    logic            iReady;
    logic [CW-1:0]   iChan;
    logic [DW-1:0]   iData;
    logic            iLast;

    // egress word stream
    logic            oValid;
    logic            oReady;
    logic [CW-1:0]   oChan;
    logic [DW-1:0]   oData;
    logic            oLast;

    // packet completion acknowledge and error flag
    logic            ackClk;
    logic [LENW-1:0] ackLen;
    logic [CW-1:0]   ackChan;
    logic            errDrop;

    modport master (
        output iValid, iChan, iData, iLast, oReady,
        input  iReady, oValid, oChan, oData, oLast,
        input  ackClk, ackLen, ackChan, errDrop
    );

    modport slave (
        input  iValid, iChan, iData, iLast, oReady,
        output iReady, oValid, oChan, oData, oLast,
        output ackClk, ackLen, ackChan, errDrop
    );
endinterface

// File: rtl/gfifo_mc_ififo_pkt.sv
// Multi-channel ingress packet FIFO.
// NCH independent circular word queues share one ingress port; whole packets
// are drained round-robin onto a single egress port. Every completed egress
// packet toggles ackClk and reports its length and channel.
module gfifo_mc_ififo_pkt #(
    parameter int DW    = 256,
    parameter int DEPTH = 1024,
    parameter int NCH   = 4,
    parameter int LENW  = 18
) (
    input  logic                 fclk,
    input  logic                 hssResetN,
    input  logic                 cutThrough,
    gfifo_mc_ififo_pkt_if.slave  bus
);
    localparam int              CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [LENW-1:0] LEN_MAX = '1;
    localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state;

    // Each entry keeps the end-of-packet marker above the data word.
    logic [DW:0]     mem [NCH][DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wptr [NCH];
    logic [AW:0]     rptr [NCH];
    // Complete packets held per channel; at most DEPTH since every packet has a word.
    logic [AW:0]     pkt_cnt [NCH];

    logic [NCH-1:0]  empty;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  eligible;
    logic [NCH-1:0]  pkt_inc;
    logic [NCH-1:0]  pkt_dec;

    logic            chan_ok;
    logic            sel_full;
    logic            wr_en;
    logic            rd_en;
    logic [DW:0]     head;

    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   grant_ch;
    logic            grant_found;

    logic [CW-1:0]   out_chan;
    logic [LENW-1:0] len_cnt;
    logic [LENW-1:0] len_inc;
    logic            ack_clk;
    logic [LENW-1:0] ack_len;
    logic [CW-1:0]   ack_chan;
    logic            err_drop;

    // Words addressed to a channel that does not exist are always accepted and thrown away.
    assign chan_ok = (int'(bus.iChan) < NCH);

    // Per-channel queue status, arbitration eligibility and packet count events.
    always_comb begin
        sel_full = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            empty[c]    = (wptr[c] == rptr[c]);
            full[c]     = (wptr[c][AW] != rptr[c][AW]) &&
                          (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
            // A full queue is eligible even without a whole packet, otherwise a
            // packet longer than the queue could never make progress.
            eligible[c] = cutThrough ? !empty[c] : ((pkt_cnt[c] != '0) || full[c]);
            pkt_inc[c]  = wr_en && bus.iLast && (bus.iChan == CW'(c));
            pkt_dec[c]  = rd_en && head[DW] && (out_chan == CW'(c));
            if (bus.iChan == CW'(c)) begin
                sel_full = full[c];
            end
        end
    end

    assign bus.iReady = !chan_ok || !sel_full;
    assign wr_en      = bus.iValid && bus.iReady && chan_ok;

    // Egress reads the head entry of the granted channel combinationally, so the
    // word stays stable for as long as the consumer stalls.
    assign head       = mem[out_chan][rptr[out_chan][AW-1:0]];
    assign bus.oValid = (state == SEND) && !empty[out_chan];
    assign bus.oData  = head[DW-1:0];
    assign bus.oLast  = head[DW];
    assign bus.oChan  = out_chan;
    assign rd_en      = bus.oValid && bus.oReady;

    assign len_inc    = (len_cnt == LEN_MAX) ? LEN_MAX : len_cnt + 1'b1;

    assign bus.ackClk  = ack_clk;
    assign bus.ackLen  = ack_len;
    assign bus.ackChan = ack_chan;
    assign bus.errDrop = err_drop;

    // Round-robin search for the first eligible channel after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!grant_found && eligible[(int'(last_grant) + k) % NCH]) begin
                grant_found = 1'b1;
                grant_ch    = CW'((int'(last_grant) + k) % NCH);
            end
        end
    end

    // Queue storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge fclk) begin
        if (wr_en) begin
            mem[bus.iChan][wptr[bus.iChan][AW-1:0]] <= {bus.iLast, bus.iData};
        end
    end

    // Pointer and complete-packet bookkeeping for every channel queue.
    always_ff @(posedge fclk or negedge hssResetN) begin
        if (!hssResetN) begin
            for (int c = 0; c < NCH; c++) begin
                wptr[c]    <= '0;
                rptr[c]    <= '0;
                pkt_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_en && (bus.iChan == CW'(c))) begin
                    wptr[c] <= wptr[c] + 1'b1;
                end
                if (rd_en && (out_chan == CW'(c))) begin
                    rptr[c] <= rptr[c] + 1'b1;
                end
                case ({pkt_inc[c], pkt_dec[c]})
                    2'b10:   pkt_cnt[c] <= pkt_cnt[c] + 1'b1;
                    2'b01:   pkt_cnt[c] <= pkt_cnt[c] - 1'b1;
                    default: pkt_cnt[c] <= pkt_cnt[c];
                endcase
            end
        end
    end

    // Grant/send state machine with registered channel, length and acknowledge outputs.
    always_ff @(posedge fclk or negedge hssResetN) begin
        if (!hssResetN) begin
            state      <= IDLE;
            out_chan   <= '0;
            last_grant <= LAST_CH;
            len_cnt    <= '0;
            ack_clk    <= 1'b0;
            ack_len    <= '0;
            ack_chan   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        out_chan   <= grant_ch;
                        last_grant <= grant_ch;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (rd_en) begin
                        if (head[DW]) begin
                            state    <= IDLE;
                            ack_clk  <= ~ack_clk;
                            ack_len  <= len_inc;
                            ack_chan <= out_chan;
                            len_cnt  <= '0;
                        end else begin
                            len_cnt  <= len_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-cycle flag for an ingress word that was discarded for a bad channel.
    always_ff @(posedge fclk or negedge hssResetN) begin
        if (!hssResetN) begin
            err_drop <= 1'b0;
        end else begin
            err_drop <= bus.iValid && !chan_ok;
        end
    end
endmodule
